// File: rtl/axin_pkt_fifo_pkg.sv
// Shared definitions for the AXIN packet FIFO: stored-word layout, drop-counter
// width and the write-side state encoding.
package axin_pkt_fifo_pkg;

   localparam int DROPS_W  = 16;
   localparam int DATA_LSB = 0;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_FILL = 2'd1,
      WR_DROP = 2'd2
   } wr_state_t;

   // Stored word is {LAST, BYTES, DATA} with DATA in the low bits
   function automatic int bytes_lsb(input int dw);
      return DATA_LSB + dw;
   endfunction

   function automatic int last_bit(input int dw, input int wbits);
      return DATA_LSB + dw + wbits;
   endfunction

   function automatic int word_w(input int dw, input int wbits);
      return dw + wbits + 1;
   endfunction

endpackage

// File: rtl/axin_pkt_fifo_mem.sv
// Simple dual-port RAM for the packet FIFO: one write port, one read port whose
// output register holds its value until the next read enable.
module axin_pkt_fifo_mem
   import axin_pkt_fifo_pkg::*;
#(
   parameter int AW = 9,
   parameter int WW = 68
) (
   input  logic          i_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [WW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [WW-1:0] rd_data
);

   logic [WW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axin_pkt_fifo.sv
// Store-and-forward AXIN packet FIFO: whole packets are committed before M_CHREQ.
// Build option AXIN_PKT_FIFO_STATS_EN enables the saturating o_drops counter.
module axin_pkt_fifo
   import axin_pkt_fifo_pkg::*;
#(
   parameter int DW     = 64,
   parameter int WBITS  = $clog2(DW/8),
   parameter int LGFIFO = 9,
   parameter int LGPKTS = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               S_VALID,
   output logic               S_READY,
   input  logic [DW-1:0]      S_DATA,
   input  logic [WBITS-1:0]   S_BYTES,
   input  logic               S_LAST,
   input  logic               S_ABORT,
   output logic               M_CHREQ,
   input  logic               M_ALLOC,
   output logic               M_VALID,
   input  logic               M_READY,
   output logic [DW-1:0]      M_DATA,
   output logic [WBITS-1:0]   M_BYTES,
   output logic               M_LAST,
   output logic               M_ABORT,
   output logic [DROPS_W-1:0] o_drops,
   output logic               o_overflow
);

   localparam int WW   = word_w(DW, WBITS);
   localparam int BLSB = bytes_lsb(DW);
   localparam int LBIT = last_bit(DW, WBITS);
   localparam logic [LGPKTS-1:0] PKT_MAX = '1;

   wr_state_t         wr_state, wr_next;
   logic [LGFIFO:0]   wr_spec, wr_commit, rd_ptr;
   logic [LGPKTS-1:0] pkt_count;
   logic              rd_busy, m_valid_r, overflow_r;
   logic              full, wr_en, commit, rewind, ovf_evt;
   logic              m_accept, rd_load, pkt_dec;
   logic [WW-1:0]     rd_word;

   // Full compares against the read pointer so space frees as soon as a word moves to the output register
   assign full = (wr_spec[LGFIFO] != rd_ptr[LGFIFO]) &&
                 (wr_spec[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);

   always_comb begin
      wr_next = wr_state;
      S_READY = 1'b1;
      wr_en   = 1'b0;
      commit  = 1'b0;
      rewind  = 1'b0;
      ovf_evt = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            S_READY = !full && (pkt_count != PKT_MAX);
            if (S_VALID && S_READY) begin
               wr_en = 1'b1;
               if (S_LAST) commit  = 1'b1;
               else        wr_next = WR_FILL;
            end
         end
         WR_FILL: begin
            if (S_ABORT) begin
               rewind  = 1'b1;
               wr_next = WR_IDLE;
            end else if (S_VALID) begin
               if (full) begin
                  rewind  = 1'b1;
                  ovf_evt = 1'b1;
                  wr_next = S_LAST ? WR_IDLE : WR_DROP;
               end else begin
                  wr_en = 1'b1;
                  if (S_LAST) begin
                     commit  = 1'b1;
                     wr_next = WR_IDLE;
                  end
               end
            end
         end
         WR_DROP: begin
            if (S_ABORT || (S_VALID && S_LAST))
               wr_next = WR_IDLE;
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_state  <= WR_IDLE;
         wr_spec   <= '0;
         wr_commit <= '0;
      end else begin
         wr_state <= wr_next;
         if (rewind)     wr_spec <= wr_commit;
         else if (wr_en) wr_spec <= wr_spec + 1'b1;
         if (commit)     wr_commit <= wr_spec + 1'b1;
      end
   end

   // Read side: only words behind wr_commit are ever fetched
   assign M_CHREQ  = (pkt_count != '0) || rd_busy;
   assign m_accept = m_valid_r && M_READY && M_ALLOC;
   assign rd_load  = (!m_valid_r || m_accept) && M_CHREQ && M_ALLOC && (rd_ptr != wr_commit);
   assign pkt_dec  = m_accept && rd_word[LBIT];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rd_ptr     <= '0;
         m_valid_r  <= 1'b0;
         rd_busy    <= 1'b0;
         pkt_count  <= '0;
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= ovf_evt;
         if (rd_load) rd_ptr <= rd_ptr + 1'b1;
         if (rd_load)       m_valid_r <= 1'b1;
         else if (m_accept) m_valid_r <= 1'b0;
         if (rd_load)      rd_busy <= 1'b1;
         else if (pkt_dec) rd_busy <= 1'b0;
         if (commit && !pkt_dec)      pkt_count <= pkt_count + 1'b1;
         else if (!commit && pkt_dec) pkt_count <= pkt_count - 1'b1;
      end
   end

   axin_pkt_fifo_mem #(
      .AW (LGFIFO),
      .WW (WW)
   ) u_mem (
      .i_clk   (i_clk),
      .wr_en   (wr_en),
      .wr_addr (wr_spec[LGFIFO-1:0]),
      .wr_data ({S_LAST, S_BYTES, S_DATA}),
      .rd_en   (rd_load),
      .rd_addr (rd_ptr[LGFIFO-1:0]),
      .rd_data (rd_word)
   );

   assign M_VALID    = m_valid_r;
   assign M_DATA     = rd_word[DATA_LSB +: DW];
   assign M_BYTES    = rd_word[BLSB +: WBITS];
   assign M_LAST     = m_valid_r && rd_word[LBIT];
   assign M_ABORT    = 1'b0;
   assign o_overflow = overflow_r;

`ifdef AXIN_PKT_FIFO_STATS_EN
   logic [DROPS_W-1:0] drops;

   // Every rewind is exactly one dropped packet (abort or overflow)
   always_ff @(posedge i_clk) begin
      if (i_reset)
         drops <= '0;
      else if (rewind && (drops != '1))
         drops <= drops + 1'b1;
   end

   assign o_drops = drops;
`else
   assign o_drops = '0;
`endif

endmodule
